// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the fetch/data memory port arbiter.
// The memory map is split into a read-only ROM half and a writable RAM half.
package mem_port_arbiter_pkg;

    localparam int IDX_W     = 11;
    localparam int CNT_W     = 4;

    localparam int Rom_base  = 0;
    localparam int Rom_size  = 1024;
    localparam int Ram_base  = 1024;
    localparam int Ram_size  = 1024;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    // One access is in flight at most; this records what its response must look like.
    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
        logic   we;
    } slot_t;

endpackage

// File: rtl/mem_port_arbiter_mem_addr_check.sv
// Byte address to word index conversion plus legality decode for one requester.
module mem_addr_check
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_WORDS = 2048,
    parameter int ROM_WORDS = 1024
) (
    input  logic [63:0]      addr,
    input  logic             we,
    output logic [IDX_W-1:0] idx,
    output logic             err
);

    localparam logic [63:0]      BYTE_LIM = 64'(MEM_WORDS) * 64'd4;
    localparam logic [IDX_W-1:0] ROM_LIM  = IDX_W'(ROM_WORDS);

    logic misaligned;
    logic out_of_range;
    logic rom_write;

    always_comb begin
        idx          = addr[IDX_W+1:2];
        misaligned   = (addr[1:0] != 2'b00);
        // Any upper bit set lands here as well, since the compare spans all 64 bits.
        out_of_range = (addr >= BYTE_LIM);
        rom_write    = we && (idx < ROM_LIM);
        err          = misaligned || out_of_range || rom_write;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port on-chip memory between instruction fetch and the data bus,
// with a fixed one-cycle response latency and a starvation guard for fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_WORDS    = 2048,
    parameter int ROM_WORDS    = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             if_req,
    input  logic [63:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    output logic             if_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [63:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [63:0]      chk_addr [2];
    logic             chk_we   [2];
    logic [IDX_W-1:0] chk_idx  [2];
    logic             chk_err  [2];

    assign chk_addr[0] = if_addr;
    assign chk_we[0]   = 1'b0;
    assign chk_addr[1] = d_addr;
    assign chk_we[1]   = d_we;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chk
            mem_addr_check #(
                .MEM_WORDS (MEM_WORDS),
                .ROM_WORDS (ROM_WORDS)
            ) u_chk (
                .addr (chk_addr[gi]),
                .we   (chk_we[gi]),
                .idx  (chk_idx[gi]),
                .err  (chk_err[gi])
            );
        end
    endgenerate

    slot_t            slot_reg,    slot_next;
    logic [CNT_W-1:0] starve_reg,  starve_next;
    logic [31:0]      if_hold_reg, if_hold_next;
    logic [31:0]      d_hold_reg,  d_hold_next;
    logic             if_rd_ok;
    logic             d_rd_ok;

    // Grant, memory drive and next response slot.
    always_comb begin
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        slot_next   = '0;
        starve_next = '0;

        // Outputs stay quiet while reset is held, even if requests are already up.
        if (reset_n) begin
            if (if_req && (!d_req || starve_reg == STARVE_MAX)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end

        if (if_gnt) begin
            mem_en          = !chk_err[0];
            mem_addr        = chk_idx[0];
            slot_next.valid = 1'b1;
            slot_next.owner = OWNER_IF;
            slot_next.err   = chk_err[0];
            slot_next.we    = 1'b0;
        end else if (d_gnt) begin
            mem_en          = !chk_err[1];
            mem_we          = d_we && !chk_err[1];
            mem_addr        = chk_idx[1];
            mem_wdata       = d_wdata;
            slot_next.valid = 1'b1;
            slot_next.owner = OWNER_D;
            slot_next.err   = chk_err[1];
            slot_next.we    = d_we;
        end

        if (if_req && !if_gnt) begin
            starve_next = (starve_reg == STARVE_MAX) ? starve_reg : starve_reg + 1'b1;
        end
    end

    // Response side: the hold value doubles as the live rdata, so a fresh read
    // appears combinationally and an error forces zero.
    always_comb begin
        if_rvalid = slot_reg.valid && (slot_reg.owner == OWNER_IF);
        d_rvalid  = slot_reg.valid && (slot_reg.owner == OWNER_D);
        if_err    = if_rvalid && slot_reg.err;
        d_err     = d_rvalid && slot_reg.err;
        if_rd_ok  = if_rvalid && !slot_reg.err;
        d_rd_ok   = d_rvalid && !slot_reg.err && !slot_reg.we;

        if_hold_next = if_hold_reg;
        if (if_rd_ok) begin
            if_hold_next = mem_rdata;
        end else if (if_err) begin
            if_hold_next = '0;
        end

        d_hold_next = d_hold_reg;
        if (d_rd_ok) begin
            d_hold_next = mem_rdata;
        end else if (d_err) begin
            d_hold_next = '0;
        end

        if_rdata = if_hold_next;
        d_rdata  = d_hold_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_reg    <= '0;
            starve_reg  <= '0;
            if_hold_reg <= '0;
            d_hold_reg  <= '0;
        end else begin
            slot_reg    <= slot_next;
            starve_reg  <= starve_next;
            if_hold_reg <= if_hold_next;
            d_hold_reg  <= d_hold_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port memory attached.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [63:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        ld_en = 1'b0;
    logic [10:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] mem [2048];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_WORDS    (2048),
        .ROM_WORDS    (1024),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory with registered read; ld_* preloads words from the bench.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic preload(input logic [10:0] a, input logic [31:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_idle();
        if_req = 1'b1; d_req = 1'b1;
        preload(11'd0,    32'h0000_0013);
        preload(11'd1,    32'h0010_0093);
        preload(11'd512,  32'h1111_1111);
        preload(11'd1025, 32'h55AA_55AA);
        #1;
        checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); end
        checks++; if ({if_rvalid, if_err, d_rvalid, d_err} !== 4'b0) begin errors++; $display("FAIL reset_rsp: got %b want 0000", {if_rvalid, if_err, d_rvalid, d_err}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h0;
        #1;
        checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt: got if=%b d=%b want 1/0", if_gnt, d_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 11'd0) begin errors++; $display("FAIL fetch_mem: got en=%b we=%b addr=%0d want 1/0/0", mem_en, mem_we, mem_addr); end
        @(posedge clk); #1;
        checks++; if (if_rvalid !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h0000_0013) begin errors++; $display("FAIL fetch_rsp: got v=%b e=%b d=%h want 1/0/00000013", if_rvalid, if_err, if_rdata); end
        $display("txn fetch 0x0 -> %h", if_rdata);
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0000_0013) begin errors++; $display("FAIL fetch_hold: got v=%b d=%h want 0/00000013", if_rvalid, if_rdata); end
    endtask

    task automatic test_read_after_write();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h1000; d_wdata = 32'hCAFE_BABE;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd1024 || mem_wdata !== 32'hCAFE_BABE) begin
            errors++; $display("FAIL raw_write_grant: got g=%b en=%b we=%b a=%0d wd=%h want 1/1/1/1024/cafebabe", d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b0) begin errors++; $display("FAIL raw_write_rsp: got v=%b e=%b want 1/0", d_rvalid, d_err); end
        $display("txn write 0x1000 <- cafebabe");
        @(negedge clk);
        d_we = 1'b0; d_wdata = '0;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL raw_read_grant: got g=%b en=%b we=%b want 1/1/0", d_gnt, mem_en, mem_we); end
        @(posedge clk); #1;
        checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL raw_read_rsp: got v=%b e=%b d=%h want 1/0/cafebabe", d_rvalid, d_err, d_rdata); end
        $display("txn read 0x1000 -> %h", d_rdata);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_errors();
        logic [63:0] bad_addr [4];
        bad_addr[0] = 64'h0000_0800;
        bad_addr[1] = 64'h0000_1002;
        bad_addr[2] = 64'h0000_2000;
        bad_addr[3] = 64'h1_0000_1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d_req = 1'b1; d_we = (i == 0); d_addr = bad_addr[i]; d_wdata = 32'hDEAD_BEEF;
            #1;
            checks++; if (d_gnt !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL err_grant[%0d]: got g=%b en=%b we=%b want 1/0/0", i, d_gnt, mem_en, mem_we); end
            @(posedge clk); #1;
            checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL err_rsp[%0d]: got v=%b e=%b d=%h want 1/1/0", i, d_rvalid, d_err, d_rdata); end
            $display("txn bad access %h -> err=%b", bad_addr[i], d_err);
        end
        @(negedge clk);
        d_we = 1'b0; d_addr = 64'h800; d_wdata = '0;
        @(posedge clk); #1;
        checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h1111_1111) begin errors++; $display("FAIL rom_unchanged: got v=%b e=%b d=%h want 1/0/11111111", d_rvalid, d_err, d_rdata); end
        $display("txn read 0x800 -> %h", d_rdata);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_starve();
        logic exp_if;
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h1000;
        for (int k = 0; k < 10; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            exp_if = (k % 5 == 4);
            checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin errors++; $display("FAIL starve_pattern[%0d]: got if=%b d=%b want %b/%b", k, if_gnt, d_gnt, exp_if, !exp_if); end
            $display("txn starve cycle %0d grant=%s", k, if_gnt ? "IF" : "D");
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] addr_tab [4];
        logic [31:0] exp_tab  [4];
        addr_tab[0] = 64'h0;    exp_tab[0] = 32'h0000_0013;
        addr_tab[1] = 64'h1000; exp_tab[1] = 32'hCAFE_BABE;
        addr_tab[2] = 64'h4;    exp_tab[2] = 32'h0010_0093;
        addr_tab[3] = 64'h1004; exp_tab[3] = 32'h55AA_55AA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_idle();
            if (k % 2 == 0) begin if_req = 1'b1; if_addr = addr_tab[k]; end
            else begin d_req = 1'b1; d_addr = addr_tab[k]; end
            @(posedge clk); #1;
            if (k % 2 == 0) begin
                checks++; if (if_rvalid !== 1'b1 || d_rvalid !== 1'b0 || if_rdata !== exp_tab[k]) begin errors++; $display("FAIL b2b_if[%0d]: got iv=%b dv=%b d=%h want 1/0/%h", k, if_rvalid, d_rvalid, if_rdata, exp_tab[k]); end
            end else begin
                checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || d_rdata !== exp_tab[k]) begin errors++; $display("FAIL b2b_d[%0d]: got dv=%b iv=%b d=%h want 1/0/%h", k, d_rvalid, if_rvalid, d_rdata, exp_tab[k]); end
            end
            $display("txn b2b %0d addr %h if_rvalid=%b d_rvalid=%b", k, addr_tab[k], if_rvalid, d_rvalid);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_no_extra: got iv=%b dv=%b want 0/0", if_rvalid, d_rvalid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h1000;
        @(posedge clk); #1;
        drive_idle();
        reset_n = 1'b0;
        #1;
        checks++; if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, if_err, d_err} !== 8'b0) begin errors++; $display("FAIL midrst_ctrl: got %b want 00000000", {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, if_err, d_err}); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
        @(negedge clk);
        reset_n = 1'b1;
        $display("txn mid-operation reset released");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_no_rvalid[%0d]: got iv=%b dv=%b want 0/0", k, if_rvalid, d_rvalid); end
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h4;
        #1;
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 11'd1) begin errors++; $display("FAIL midrst_regrant: got g=%b a=%0d want 1/1", if_gnt, mem_addr); end
        @(posedge clk); #1;
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0010_0093) begin errors++; $display("FAIL midrst_regrant_rsp: got v=%b d=%h want 1/00100093", if_rvalid, if_rdata); end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_read_after_write();
        test_errors();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
